// File: rtl/rx_fcs_pkg.sv
// Shared constants and payload types for the RX FCS checker and CRC helpers.
package rx_fcs_pkg;

    localparam int unsigned LEN_W       = 11;
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    // Per-frame status payload.
    typedef struct packed {
        logic             fcs_err;
        logic             runt;
        logic [LEN_W-1:0] len;
    } frame_stat_t;

endpackage

// File: rtl/rx_fcs_check_crc32_d8.sv
// Combinational reflected CRC-32 update for one byte, LSB first.
module crc32_d8
    import rx_fcs_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next_c
);

    // Eight serial LFSR steps unrolled into one combinational stage.
    always_comb begin
        crc_next_c = crc;
        for (int i = 0; i < 8; i++) begin
            if (crc_next_c[0] ^ data[i]) begin
                crc_next_c = (crc_next_c >> 1) ^ CRC_POLY;
            end else begin
                crc_next_c = crc_next_c >> 1;
            end
        end
    end

endmodule

// File: rtl/rx_fcs_check.sv
// RX FCS checker: pulls bytes from the RX FIFO, checks Ethernet CRC-32,
// forwards bytes downstream and reports per-frame status and counters.
// Optional macro FCS_STRIP_EN: the 4 FCS bytes are not forwarded.
module rx_fcs_check
    import rx_fcs_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned MIN_LEN = 64
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [7:0]       i_fifo_dout,
    input  logic             i_fifo_empty,
    input  logic             i_fifo_del,
    output logic             i_fifo_rden,
    output logic [7:0]       o_fifo_din,
    output logic             o_fifo_wren,
    output logic             o_fifo_del,
    input  logic             o_fifo_afull,
    output logic             o_stat_valid,
    output logic             o_stat_fcs_err,
    output logic             o_stat_runt,
    output logic [LEN_W-1:0] o_stat_len,
    output logic [CNT_W-1:0] o_good_cnt,
    output logic [CNT_W-1:0] o_bad_cnt
);

    logic             rd_vld;
    logic [31:0]      crc_q;
    logic [31:0]      crc_nxt_c;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_nxt_c;
    frame_stat_t      stat_c;
    logic             del_smp_c;

    // Reads are gated only by source data and downstream headroom.
    assign i_fifo_rden = !i_fifo_empty && !o_fifo_afull;
    assign del_smp_c   = rd_vld && i_fifo_del;

    crc32_d8 u_crc (
        .crc        (crc_q),
        .data       (i_fifo_dout),
        .crc_next_c (crc_nxt_c)
    );

    // Length including the current byte, saturating at all-ones.
    always_comb begin
        len_nxt_c = (len_q == {LEN_W{1'b1}}) ? len_q : len_q + LEN_W'(1);
        stat_c.fcs_err = (crc_nxt_c != CRC_RESIDUE);
        stat_c.runt    = (len_nxt_c < LEN_W'(MIN_LEN));
        stat_c.len     = len_nxt_c;
    end

    // Read-valid pipeline plus CRC/length accumulation; reload after the del byte.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_vld <= 1'b0;
            crc_q  <= CRC_INIT;
            len_q  <= '0;
        end else begin
            rd_vld <= i_fifo_rden;
            if (rd_vld) begin
                if (i_fifo_del) begin
                    crc_q <= CRC_INIT;
                    len_q <= '0;
                end else begin
                    crc_q <= crc_nxt_c;
                    len_q <= len_nxt_c;
                end
            end
        end
    end

    // Frame status strobe, aligned with the final write of the frame.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            o_stat_valid   <= 1'b0;
            o_stat_fcs_err <= 1'b0;
            o_stat_runt    <= 1'b0;
            o_stat_len     <= '0;
        end else begin
            o_stat_valid <= del_smp_c;
            if (del_smp_c) begin
                o_stat_fcs_err <= stat_c.fcs_err;
                o_stat_runt    <= stat_c.runt;
                o_stat_len     <= stat_c.len;
            end
        end
    end

    // Saturating good/bad counters, updated the cycle after the status strobe.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            o_good_cnt <= '0;
            o_bad_cnt  <= '0;
        end else if (o_stat_valid) begin
            if (o_stat_fcs_err || o_stat_runt) begin
                if (o_bad_cnt != {CNT_W{1'b1}}) begin
                    o_bad_cnt <= o_bad_cnt + CNT_W'(1);
                end
            end else if (o_good_cnt != {CNT_W{1'b1}}) begin
                o_good_cnt <= o_good_cnt + CNT_W'(1);
            end
        end
    end

`ifdef FCS_STRIP_EN
    logic [3:0][7:0] dly_q;
    logic [2:0]      occ_q;
    logic            push_out_c;

    assign push_out_c = rd_vld && (occ_q == 3'd4);

    // Four-byte delay line: only bytes pushed out by a newer sample are written,
    // so the trailing FCS never leaves; occupancy restarts at each frame.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            dly_q       <= '0;
            occ_q       <= '0;
            o_fifo_wren <= 1'b0;
            o_fifo_din  <= '0;
            o_fifo_del  <= 1'b0;
        end else begin
            o_fifo_wren <= push_out_c;
            o_fifo_del  <= push_out_c && i_fifo_del;
            if (push_out_c) begin
                o_fifo_din <= dly_q[3];
            end
            if (rd_vld) begin
                dly_q <= {dly_q[2:0], i_fifo_dout};
                if (i_fifo_del) begin
                    occ_q <= '0;
                end else if (occ_q != 3'd4) begin
                    occ_q <= occ_q + 3'd1;
                end
            end
        end
    end
`else
    // Straight pass-through of every sampled byte with its del bit.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            o_fifo_wren <= 1'b0;
            o_fifo_din  <= '0;
            o_fifo_del  <= 1'b0;
        end else begin
            o_fifo_wren <= rd_vld;
            o_fifo_del  <= del_smp_c;
            if (rd_vld) begin
                o_fifo_din <= i_fifo_dout;
            end
        end
    end
`endif

endmodule
